// File: rtl/muxn_pkg.sv
// Shared types and helpers for the N-to-1 registered multiplexer/arbiter.
package muxn_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_t;

  // Next channel index with wrap-around at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/muxn_arb_if.sv
// Producer/consumer bundle for muxn_arb: N input channels, one output channel.
interface muxn_arb_if #(
  parameter int N = 4,
  parameter int W = 1
);
  import muxn_pkg::*;

  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  mux_mode_t      mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  // Environment side: drives producers and the consumer's ready.
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search: first requester after ptr, wrapping.
module rr_arbiter
  import muxn_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          grant_vld,
  output logic [SW-1:0] grant_idx
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default first so no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = int'(ptr);
    for (int k = 0; k < N; k++) begin
      cand = wrap_inc(cand, N);
      for (int i = 0; i < N; i++) begin
        if (!grant_vld && cand == i && req[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// N-to-1 registered mux with explicit-select or round-robin grant and one-entry output register.
module muxn_arb
  import muxn_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  muxn_arb_if.slave bus
);

  localparam int SW = $clog2(N);

  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          sel_vld;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic          can_accept;
  logic          in_xfer;

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  rr_arbiter #(.N(N)) u_rr (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .grant_vld (rr_vld),
    .grant_idx (rr_idx)
  );

  // Compare against each legal index so a sel beyond N-1 can never match.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SW'(i) && bus.in_valid[i]) sel_vld = 1'b1;
    end
  end

  assign grant_vld  = (bus.mode == MODE_RR) ? rr_vld : sel_vld;
  assign grant_idx  = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
  assign can_accept = !out_valid_q || bus.out_ready;
  // rst_n gates the handshake so no producer sees ready while reset is held.
  assign in_xfer    = grant_vld && can_accept && rst_n;

  always_comb begin
    bus.in_ready = '0;
    grant_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        bus.in_ready[i] = in_xfer;
        grant_data      = bus.in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (in_xfer) begin
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to N-1 so the first round-robin search starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(N - 1);
    end else begin
      // NOTE: non-blocking assignments keep register updates order-independent.
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_muxn_arb.sv
// Self-checking bench for muxn_arb: N=4 and N=3 instances against a behavioural model.
module tb_muxn_arb;
  import muxn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muxn_arb_if #(.N(4), .W(8)) ia ();
  muxn_arb_if #(.N(3), .W(8)) ib ();

  muxn_arb #(.N(4), .W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  muxn_arb #(.N(3), .W(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int tests = 0;
  int fails = 0;

  // Model state per instance: 0 = N=4, 1 = N=3.
  int         nch [2] = '{4, 3};
  int         m_ptr [2];
  bit         m_vld [2];
  logic [7:0] m_data [2];
  int         m_ch [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d]  = 1'b0;
      m_data[d] = 8'h00;
      m_ch[d]   = 0;
      m_ptr[d]  = nch[d] - 1;
    end
  endtask

  // Channel granted under the arbitration rules, or -1 for none.
  function automatic int ref_grant(input int d, input logic [3:0] v, input mux_mode_t m, input int s);
    int c;
    if (m == MODE_SEL) return (s < nch[d] && v[s]) ? s : -1;
    for (int k = 1; k <= nch[d]; k++) begin
      c = (m_ptr[d] + k) % nch[d];
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Called at a falling edge after inputs are driven; returns at the next falling edge.
  task automatic cycle();
    logic [3:0] v [2];
    mux_mode_t  md [2];
    int         s [2];
    logic       rdy [2];
    logic [7:0] dat [2][4];
    logic [3:0] rdy_obs [2];
    int         g [2];
    bit         acc [2];
    #1;
    v[0] = ia.in_valid;          v[1] = {1'b0, ib.in_valid};
    md[0] = ia.mode;             md[1] = ib.mode;
    s[0] = int'(ia.sel);         s[1] = int'(ib.sel);
    rdy[0] = ia.out_ready;       rdy[1] = ib.out_ready;
    rdy_obs[0] = ia.in_ready;    rdy_obs[1] = {1'b0, ib.in_ready};
    for (int c = 0; c < 4; c++) dat[0][c] = ia.in_data[c*8 +: 8];
    for (int c = 0; c < 3; c++) dat[1][c] = ib.in_data[c*8 +: 8];
    dat[1][3] = 8'h00;
    for (int d = 0; d < 2; d++) begin
      g[d]   = ref_grant(d, v[d], md[d], s[d]);
      acc[d] = !m_vld[d] || rdy[d];
      check(d == 0 ? "a_in_ready" : "b_in_ready", 32'(rdy_obs[d]),
            (g[d] >= 0 && acc[d]) ? (32'd1 << g[d]) : 32'd0);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (g[d] >= 0 && acc[d]) begin
        m_vld[d]  = 1'b1;
        m_data[d] = dat[d][g[d]];
        m_ch[d]   = g[d];
        m_ptr[d]  = g[d];
      end else if (rdy[d]) begin
        m_vld[d] = 1'b0;
      end
    end
    @(negedge clk);
    check("a_out_valid", 32'(ia.out_valid), 32'(m_vld[0]));
    check("a_out_data",  32'(ia.out_data),  32'(m_data[0]));
    check("a_out_ch",    32'(ia.out_ch),    32'(m_ch[0]));
    check("b_out_valid", 32'(ib.out_valid), 32'(m_vld[1]));
    check("b_out_data",  32'(ib.out_data),  32'(m_data[1]));
    check("b_out_ch",    32'(ib.out_ch),    32'(m_ch[1]));
  endtask

  initial begin
    rst_n        = 1'b0;
    ia.in_valid  = 4'hF;
    ia.in_data   = '0;
    ia.mode      = MODE_RR;
    ia.sel       = '0;
    ia.out_ready = 1'b1;
    ib.in_valid  = '0;
    ib.in_data   = '0;
    ib.mode      = MODE_RR;
    ib.sel       = '0;
    ib.out_ready = 1'b1;
    model_reset();

    // Reset state with all channels requesting.
    #3;
    check("rst_out_valid", 32'(ia.out_valid), 32'd0);
    check("rst_out_data",  32'(ia.out_data),  32'd0);
    check("rst_out_ch",    32'(ia.out_ch),    32'd0);
    check("rst_in_ready",  32'(ia.in_ready),  32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_in_ready", 32'(ia.in_ready), 32'd0);
    check("rst_hold_valid",    32'(ia.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness from reset.
    ia.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_seq", 32'(ia.out_ch), 32'(i % 4));
    end

    // Explicit select.
    ia.mode    = MODE_SEL;
    ia.sel     = 2'd2;
    ia.in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    cycle();
    check("sel_data", 32'(ia.out_data), 32'hA5);
    check("sel_ch",   32'(ia.out_ch),   32'd2);
    ia.sel      = 2'd3;
    ia.in_valid = 4'b0111;
    cycle();
    check("sel_idle_valid", 32'(ia.out_valid), 32'd0);

    // Round-robin skipping idle channels; ptr is 2 after the select phase.
    ia.mode     = MODE_RR;
    ia.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rr_skip_seq", 32'(ia.out_ch), (i % 2 == 0) ? 32'd3 : 32'd1);
    end

    // Backpressure holds the word from ch1, then drain and reload together.
    ia.in_valid  = 4'hF;
    ia.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ia.in_data = 32'($urandom());
      cycle();
      check("bp_valid", 32'(ia.out_valid), 32'd1);
      check("bp_ch",    32'(ia.out_ch),    32'd1);
    end
    ia.out_ready = 1'b1;
    cycle();
    check("drain_valid", 32'(ia.out_valid), 32'd1);
    check("drain_ch",    32'(ia.out_ch),    32'd2);

    // Non-power-of-two instance: out-of-range select, then round-robin.
    ia.in_valid  = '0;
    ib.mode      = MODE_SEL;
    ib.sel       = 2'd3;
    ib.in_valid  = 3'b111;
    ib.in_data   = {8'h22, 8'h21, 8'h20};
    cycle();
    check("b_sel3_valid", 32'(ib.out_valid), 32'd0);
    ib.mode = MODE_RR;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("b_rr_seq", 32'(ib.out_ch), 32'(i % 3));
    end

    // Randomised traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      ia.in_valid  = 4'($urandom_range(0, 15));
      ia.mode      = mux_mode_t'($urandom_range(0, 1));
      ia.sel       = 2'($urandom_range(0, 3));
      ia.out_ready = ($urandom_range(0, 3) != 0);
      ia.in_data   = 32'($urandom());
      ib.in_valid  = 3'($urandom_range(0, 7));
      ib.mode      = mux_mode_t'($urandom_range(0, 1));
      ib.sel       = 2'($urandom_range(0, 3));
      ib.out_ready = ($urandom_range(0, 3) != 0);
      ib.in_data   = 24'($urandom());
      cycle();
    end

    // Reset asserted while a word is held.
    ia.mode      = MODE_RR;
    ia.in_valid  = 4'hF;
    ia.out_ready = 1'b0;
    ib.in_valid  = '0;
    cycle();
    cycle();
    check("mr_held_valid", 32'(ia.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mr_out_valid", 32'(ia.out_valid), 32'd0);
    check("mr_out_data",  32'(ia.out_data),  32'd0);
    check("mr_out_ch",    32'(ia.out_ch),    32'd0);
    check("mr_in_ready",  32'(ia.in_ready),  32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    ia.out_ready = 1'b1;
    cycle();
    check("mr_first_ch", 32'(ia.out_ch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muxn_arb.md
# muxn_arb

Parametrised N-to-1 registered multiplexer with per-channel valid/ready handshakes. Successor to the combinational 4:1 mux: generalises channel count and data width, adds a runtime choice between explicit select and round-robin arbitration, and registers the output with backpressure. It sits between several producers and one consumer on a shared data path.

## Interface
- N, 4, number of input channels (2..16)
- W, 1, data width per channel in bits (1..64)
- SW (localparam), $clog2(N), width of select and channel tag
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_valid  input  N  channel i has data
- in_ready  output  N  channel i transfers this cycle (at most one bit high)
- mode  input  1  0 = MODE_SEL (explicit select), 1 = MODE_RR (round-robin)
- sel  input  SW  channel index used in MODE_SEL
- out_data  output  W  registered selected data
- out_ch  output  SW  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_ch hold a word
- out_ready  input  1  consumer accepts the word this cycle

## Operation
- Output register is one entry. can_accept = !out_valid | out_ready.
- Grant computed every cycle from in_valid, mode, sel and RR pointer.
  - MODE_SEL: grant = sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N (non-power-of-two N) never grants.
  - MODE_RR: grant = first i with in_valid[i], searching from (ptr+1) mod N upward with wrap; no grant if in_valid == 0.
- in_ready[grant] = can_accept; all other in_ready bits 0. No grant: in_ready = 0.
- Input transfer (in_valid[g] & in_ready[g]): out_data <= in_data[g], out_ch <= g, out_valid <= 1, ptr <= g.
- Output transfer without input transfer: out_valid <= 0; out_data/out_ch hold last value.
- Simultaneous output and input transfer: register reloads, out_valid stays 1 (full throughput, one word per cycle).
- out_valid & !out_ready: out_data, out_ch, out_valid held stable; in_ready = 0.
- ptr updates only on an input transfer, in either mode, so a switch to MODE_RR continues fairly from the last served channel.
- Mode or sel change takes effect in the same cycle's grant; never corrupts a held word.
- Input valid may drop without transfer; no state is affected.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, out_ch = 0, ptr = N-1 (first RR priority is channel 0). in_ready = 0 while rst_n low.
- Latency: input transfer in cycle t -> out_valid and data visible after edge t, i.e. cycle t+1.
- in_ready is combinational from in_valid, mode, sel, ptr and out_ready; out_* are register outputs only.
- Reset asserted mid-transfer discards the held word; no in_ready during reset; first grant on first edge after rst_n deasserts.
- RR fairness: with all N channels continuously valid and out_ready = 1, each channel granted exactly once per N consecutive cycles.

## Structure
- Package muxn_pkg: typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_t; function for wrap-around index increment.
- Sub-module rr_arbiter (params N; inputs req[N], ptr[SW]; output grant_vld, grant_idx[SW]): purely combinational rotating priority search; muxn_arb owns ptr, mode select and output register.

## Test plan
- Reset: N=4, W=8, hold rst_n low with in_valid = 4'hF -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0.
- MODE_SEL: sel = 2, in_valid = 4'hF, in_data ch2 = 8'hA5, out_ready = 1 -> in_ready = 4'b0100, next cycle out_data = 8'hA5, out_ch = 2; sel = 3 with in_valid[3] = 0 -> in_ready = 0, out_valid falls to 0.
- MODE_RR fairness: in_valid = 4'hF, out_ready = 1 for 8 cycles after reset -> out_ch sequence 0,1,2,3,0,1,2,3.
- RR skip: in_valid = 4'b1010, ptr after serving ch1 -> next grant ch3, then ch1; ch0/ch2 in_ready always 0.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles while in_data changes -> out_data/out_ch stable, in_ready = 0; out_ready = 1 -> drain and reload in one cycle, out_valid stays 1.
- Non-power-of-two: N=3, MODE_SEL, sel = 3 -> in_ready = 0, no output; MODE_RR with in_valid = 3'b111 -> out_ch 0,1,2,0.
